wb_write_arbiter: RTL
=====================

# wb_write_arbiter

- Shares the register file write ports (`we3`, `wa3`/`wd3`, `wa3_2`/`wd3_2`) between two writeback requesters: requester 0 is the ALU/long-multiply stage and requester 1 is the memory/load stage.
- Schedules up to two register writes per cycle, with round-robin fairness between the requesters.
- Redirects writes aimed at r15 to a PC-write output, because the file holds only r0–r14.
- Registers the port drive so it is stable before the file's negedge write, and optionally forwards staged data to readers.

## Interface
Parameters:
- `DW`, 32, data width.
- `AW`, 4, register address width.

Ports:
- `clk`  in  1  system clock. All state updates on posedge.
- `reset`  in  1  synchronous, active-low reset. Sampled on posedge.
- `req_valid_i` (i=0,1)  in  1  requester i presents a write.
- `req_ready_i`  out  1  combinational grant. A transfer occurs when valid & ready at posedge.
- `req_pair_i`  in  1  request carries two words (long multiply).
- `req_wa_i`, `req_wa2_i`  in  AW  first and second destination.
- `req_wd_i`, `req_wd2_i`  in  DW  first and second data.
- `we3`  out  2  00 none, 01 port A only, 11 ports A and B.
- `wa3`, `wd3`, `wa3_2`, `wd3_2`  out  AW/DW  registered port drive.
- `pc_wr_valid`  out  1  one-cycle pulse carrying a write to r15.
- `pc_wr_data`  out  DW  value written to r15.
- `chk_ra`  in  AW  forwarding query address.
- `chk_hit`  out  1  staged write matches `chk_ra`.
- `chk_data`  out  DW  forwarded value.

## Operation
**Word count and conflicts**
- A single request is 1 word; a pair request is 2 words.
- Two words conflict if they have equal addresses. All r15 words are treated as mutually conflicting.

**Grant rule**, evaluated with `ptr` as the priority holder:
- Only one requester valid: grant it.
- Both valid, both single, no conflict: grant both. Port A takes `ptr`'s word, port B takes the other's.
- Both valid, and either is a pair or the two conflict: grant `ptr` only.

**Pointer update**
- If a valid requester was not granted, `ptr` moves to it.
- Otherwise `ptr` holds.
- Guarantees each requester waits at most 1 cycle.

**Staging (posedge)**
- Granted words pack into ports A then B, in order: `ptr` word, then pair second word or other requester word.
- A word addressed to r15 does not occupy a port. It sets `pc_wr_valid`=1 and `pc_wr_data`, and the next word shifts into port A.
- `we3` is 01 for one packed word, 11 for two, 00 for none.
- A pair with `req_wa==req_wa2` (neither 15) stages both words. The file's port B write takes precedence.
- A pair with both addresses 15 gives `pc_wr_data` = second word.

**Forwarding**
- `chk_hit`=1 if `chk_ra` matches port A (`we3[0]`) or port B (`we3[1]`), with `chk_ra`≠15.
- `chk_data` is the port B value when both ports match, else the matching port's value, else 0.
- Forwarding is combinational from the stage registers.

**Reset**
- With `reset`=0 at posedge: `we3`=00, all address/data outputs 0, `pc_wr_valid`=0, `ptr`=0.
- `req_ready_0`/`req_ready_1` are forced to 0 while `reset` is low.
- A request presented during reset is not accepted and must be held by its requester.

## Timing
- Grant is combinational, in the same cycle as `req_valid`.
- Staged outputs appear 1 posedge after acceptance and remain valid for exactly 1 cycle.
- The file commits at the following negedge, i.e. half a cycle after staging.
- Empty cycles drive `we3`=00; stale addresses/data are allowed but `pc_wr_valid`=0.
- Sustained throughput: 2 single words per cycle, or 1 pair per cycle.

## Configuration
- `WB_ARB_FWD_EN` defined: the forwarding logic is built as above.
- Undefined: `chk_hit`=0 and `chk_data`=0 constant, and the `chk_ra` compare logic is omitted.
- Arbitration and staging are identical in both builds.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with both `req_valid`=1 → `req_ready`=00, `we3`=00, `pc_wr_valid`=0. After release, `ptr`=0, so requester 0 is granted first.
- **Dual single:** req0 (wa=3, wd=0x11) and req1 (wa=5, wd=0x22) → both ready. Next cycle: `we3`=11, `wa3`=3, `wd3`=0x11, `wa3_2`=5, `wd3_2`=0x22.
- **Conflict and fairness:** both target r7 for 2 consecutive cycles → cycle 1 grants req0 only; cycle 2 grants req1. Staged values are req0's then req1's.
- **Pair vs single:** req0 pair (r1=0xA, r2=0xB) with req1 single (r4) → req0 only, `we3`=11 (r1, r2). Next cycle: req1 alone, `we3`=01.
- **r15 redirect:** req1 single (wa=15, wd=0x100) plus req0 single (r2) → `pc_wr_valid`=1, `pc_wr_data`=0x100, `we3`=01, `wa3`=2.
- **Forward (`WB_ARB_FWD_EN` set):** stage ports A and B both at r6 with 0x1/0x2, `chk_ra`=6 → `chk_hit`=1, `chk_data`=0x2. With `chk_ra`=15 → `chk_hit`=0.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the two register-file write ports (A = wa3/wd3,
// B = wa3_2/wd3_2) between the ALU/long-multiply requester (0) and the
// memory/load requester (1). Up to two words are accepted per cycle with
// round-robin priority. Words aimed at r15 are diverted to a PC-write pulse
// because the file only holds r0-r14. Port drive is registered so it is
// stable before the file's negedge commit.
// Optional feature macro: WB_ARB_FWD_EN builds the chk_ra/chk_hit/chk_data
// forwarding path from the staged port registers.
module wb_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid_0,
  input  logic          req_valid_1,
  output logic          req_ready_0,
  output logic          req_ready_1,
  input  logic          req_pair_0,
  input  logic          req_pair_1,
  input  logic [AW-1:0] req_wa_0,
  input  logic [AW-1:0] req_wa2_0,
  input  logic [AW-1:0] req_wa_1,
  input  logic [AW-1:0] req_wa2_1,
  input  logic [DW-1:0] req_wd_0,
  input  logic [DW-1:0] req_wd2_0,
  input  logic [DW-1:0] req_wd_1,
  input  logic [DW-1:0] req_wd2_1,
  output logic [1:0]    we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic [AW-1:0] wa3_2,
  output logic [DW-1:0] wd3_2,
  output logic          pc_wr_valid,
  output logic [DW-1:0] pc_wr_data,
  input  logic [AW-1:0] chk_ra,
  output logic          chk_hit,
  output logic [DW-1:0] chk_data
);

  localparam logic [AW-1:0] PC_ADDR = AW'(15);

  // Per-requester views so both sides share one indexing scheme.
  logic [1:0]         vld, pair;
  logic [1:0][AW-1:0] wa, wa2;
  logic [1:0][DW-1:0] wd, wd2;

  assign vld  = {req_valid_1, req_valid_0};
  assign pair = {req_pair_1, req_pair_0};
  assign wa   = {req_wa_1, req_wa_0};
  assign wa2  = {req_wa2_1, req_wa2_0};
  assign wd   = {req_wd_1, req_wd_0};
  assign wd2  = {req_wd2_1, req_wd2_0};

  // Arbitration state and staged port drive.
  logic          ptr_q, ptr_d;
  logic [1:0]    gnt;
  logic [1:0]    we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d, wa3_2_q, wa3_2_d;
  logic [DW-1:0] wd3_q, wd3_d, wd3_2_q, wd3_2_d;
  logic          pcv_q, pcv_d;
  logic [DW-1:0] pcd_q, pcd_d;

  // Candidate words in packing order: w0 is the first granted word, w1 is
  // either the pair's second word or the other requester's word.
  logic          first;
  logic          w0_v, w1_v, w0_pc, w1_pc;
  logic [AW-1:0] w0_a, w1_a;
  logic [DW-1:0] w0_d, w1_d;

  // Grant: a lone requester always wins; two singles to different registers
  // both go; anything else (pair or same destination) goes to ptr only.
  // Equal-address compare also covers the r15-vs-r15 conflict.
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      unique case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (!pair[0] && !pair[1] && (wa[0] != wa[1])) gnt = 2'b11;
          else if (ptr_q)                               gnt = 2'b10;
          else                                          gnt = 2'b01;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req_ready_0 = gnt[0];
  assign req_ready_1 = gnt[1];

  // Priority moves to whichever valid requester lost this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (vld[0] && !gnt[0])      ptr_d = 1'b0;
    else if (vld[1] && !gnt[1]) ptr_d = 1'b1;
  end

  // Select the (up to) two accepted words in ptr-first order.
  always_comb begin
    unique case (gnt)
      2'b01:   first = 1'b0;
      2'b10:   first = 1'b1;
      default: first = ptr_q;
    endcase
    w0_v  = |gnt;
    w0_a  = wa[first];
    w0_d  = wd[first];
    w1_v  = (&gnt) | ((|gnt) & pair[first]);
    w1_a  = (&gnt) ? wa[~first] : wa2[first];
    w1_d  = (&gnt) ? wd[~first] : wd2[first];
    w0_pc = w0_v && (w0_a == PC_ADDR);
    w1_pc = w1_v && (w1_a == PC_ADDR);
  end

  // Pack surviving words into port A then B; r15 words become the PC pulse.
  // When both words hit r15 (pair) the later word is the one that sticks.
  always_comb begin
    we3_d   = 2'b00;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    wa3_2_d = wa3_2_q;
    wd3_2_d = wd3_2_q;
    pcv_d   = w0_pc | w1_pc;
    pcd_d   = pcd_q;
    if (w1_pc)      pcd_d = w1_d;
    else if (w0_pc) pcd_d = w0_d;
    if (w0_v && !w0_pc) begin
      we3_d[0] = 1'b1;
      wa3_d    = w0_a;
      wd3_d    = w0_d;
      if (w1_v && !w1_pc) begin
        we3_d[1] = 1'b1;
        wa3_2_d  = w1_a;
        wd3_2_d  = w1_d;
      end
    end else if (w1_v && !w1_pc) begin
      we3_d[0] = 1'b1;
      wa3_d    = w1_a;
      wd3_d    = w1_d;
    end
  end

  // Stage registers: one-cycle port drive, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= 1'b0;
      we3_q   <= 2'b00;
      wa3_q   <= '0;
      wd3_q   <= '0;
      wa3_2_q <= '0;
      wd3_2_q <= '0;
      pcv_q   <= 1'b0;
      pcd_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
      wa3_2_q <= wa3_2_d;
      wd3_2_q <= wd3_2_d;
      pcv_q   <= pcv_d;
      pcd_q   <= pcd_d;
    end
  end

  assign we3         = we3_q;
  assign wa3         = wa3_q;
  assign wd3         = wd3_q;
  assign wa3_2       = wa3_2_q;
  assign wd3_2       = wd3_2_q;
  assign pc_wr_valid = pcv_q;
  assign pc_wr_data  = pcd_q;

`ifdef WB_ARB_FWD_EN
  // Forward staged data to readers; port B wins because the file's
  // port B write lands last when both ports hit the same register.
  logic hit_a, hit_b;
  assign hit_a    = we3_q[0] && (wa3_q == chk_ra) && (chk_ra != PC_ADDR);
  assign hit_b    = we3_q[1] && (wa3_2_q == chk_ra) && (chk_ra != PC_ADDR);
  assign chk_hit  = hit_a | hit_b;
  assign chk_data = hit_b ? wd3_2_q : (hit_a ? wd3_q : '0);
`else
  // Forwarding not built: query address is intentionally ignored.
  logic unused_chk_ra;
  assign unused_chk_ra = ^chk_ra;
  assign chk_hit       = 1'b0;
  assign chk_data      = '0;
`endif

  // Port B never fires without port A, and two granted singles never collide.
  a_we3_shape: assert property (@(posedge clk) disable iff (!reset)
    we3 != 2'b10);
  a_dual_noconf: assert property (@(posedge clk) disable iff (!reset)
    (&gnt) |-> (wa[0] != wa[1]));

endmodule
